// File: rtl/alu_flag_if.sv
// Handshake bundle between the ALU, the status stage and the flag consumer.
// The slave side is the flag register; the master side is the ALU plus consumer.
interface alu_flag_if #(
    parameter int WIDTH = 8
);
    logic             alu_valid;
    logic             alu_ready;
    logic [WIDTH-1:0] result;
    logic             c_flag;
    logic             v_flag;
    logic [3:0]       flags_q;
    logic             flags_valid;
    logic             flags_ready;

    modport master (
        output alu_valid, result, c_flag, v_flag, flags_ready,
        input  alu_ready, flags_q, flags_valid
    );

    modport slave (
        input  alu_valid, result, c_flag, v_flag, flags_ready,
        output alu_ready, flags_q, flags_valid
    );
endinterface

// File: rtl/alu_flag_register.sv
// Registered {N,Z,C,V} status stage with multi-word carry chaining.
// Optional COND_EVAL_EN macro enables the condition-code evaluator.
module alu_flag_register #(
    parameter int WIDTH = 8,
    parameter int CHAIN_MAX = 4,
    localparam int CW = $clog2(CHAIN_MAX) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_flag_if.slave     bus,
    input  logic          chain_start,
    input  logic [CW-1:0] chain_words,
    output logic          carry_in,
    output logic          chain_busy,
    output logic          chain_done,
    input  logic [2:0]    cond_sel,
    output logic          cond_true
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CHAIN = 1'b1;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] CMAX = CW'(CHAIN_MAX);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_init;
    logic          zacc;
    logic          carry_q;
    logic          done_q;
    logic [3:0]    flags_r;
    logic          fvalid_r;

    logic accept;
    logic consume;
    logic word_z;
    logic word_n;
    logic publish;
    logic publish_z;
    logic done_d;

    assign bus.alu_ready   = !fvalid_r | bus.flags_ready;
    assign bus.flags_q     = flags_r;
    assign bus.flags_valid = fvalid_r;
    assign carry_in        = carry_q;
    assign chain_busy      = (state == CHAIN);
    assign chain_done      = done_q;

    assign accept  = bus.alu_valid & bus.alu_ready;
    assign consume = fvalid_r & bus.flags_ready;
    assign word_z  = (bus.result == '0);
    assign word_n  = bus.result[WIDTH-1];

    // Zero and oversize word counts are folded into the legal 1..CHAIN_MAX range.
    always_comb begin
        cnt_init = chain_words;
        if (chain_words == '0)
            cnt_init = ONE;
        else if (chain_words > CMAX)
            cnt_init = CMAX;
    end

    always_comb begin
        publish   = 1'b0;
        publish_z = word_z;
        done_d    = 1'b0;
        if (accept) begin
            if (state == IDLE) begin
                publish = !chain_start || (cnt_init == ONE);
                done_d  = chain_start && (cnt_init == ONE);
            end else if (cnt == ONE) begin
                publish   = 1'b1;
                publish_z = zacc & word_z;
                done_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            zacc     <= 1'b1;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            flags_r  <= 4'b0000;
            fvalid_r <= 1'b0;
        end else begin
            done_q <= done_d;
            if (publish)
                flags_r <= {word_n, publish_z, bus.c_flag, bus.v_flag};
            if (publish)
                fvalid_r <= 1'b1;
            else if (consume)
                fvalid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (chain_start && !(accept && cnt_init == ONE)) begin
                        state <= CHAIN;
                        if (accept) begin
                            cnt     <= cnt_init - ONE;
                            zacc    <= word_z;
                            carry_q <= bus.c_flag;
                        end else begin
                            cnt  <= cnt_init;
                            zacc <= 1'b1;
                        end
                    end
                end
                CHAIN: begin
                    if (accept) begin
                        if (cnt == ONE) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            zacc    <= 1'b1;
                            carry_q <= 1'b0;
                        end else begin
                            cnt     <= cnt - ONE;
                            zacc    <= zacc & word_z;
                            carry_q <= bus.c_flag;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COND_EVAL_EN
    logic cond_raw;

    always_comb begin
        cond_raw = 1'b0;
        case (cond_sel)
            3'd0: cond_raw = flags_r[2];
            3'd1: cond_raw = !flags_r[2];
            3'd2: cond_raw = flags_r[1];
            3'd3: cond_raw = !flags_r[1];
            3'd4: cond_raw = flags_r[3];
            3'd5: cond_raw = !flags_r[3];
            3'd6: cond_raw = flags_r[0];
            default: cond_raw = 1'b1;
        endcase
    end

    assign cond_true = cond_raw & fvalid_r;
`else
    logic unused_cond;

    assign unused_cond = ^cond_sel;
    assign cond_true   = 1'b0;
`endif
endmodule

// File: tb/tb_alu_flag_register.sv
// Directed vector bench for alu_flag_register (WIDTH=8, CHAIN_MAX=4).
// Condition expectations follow the COND_EVAL_EN build setting.
module tb_alu_flag_register;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chain_start = 1'b0;
    logic [2:0] chain_words = 3'd0;
    logic       carry_in;
    logic       chain_busy;
    logic       chain_done;
    logic [2:0] cond_sel = 3'd0;
    logic       cond_true;

    int errors = 0;
    int checks = 0;

    alu_flag_if #(.WIDTH(8)) bus ();

    alu_flag_register #(.WIDTH(8), .CHAIN_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .chain_start (chain_start),
        .chain_words (chain_words),
        .carry_in    (carry_in),
        .chain_busy  (chain_busy),
        .chain_done  (chain_done),
        .cond_sel    (cond_sel),
        .cond_true   (cond_true)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       cs;
        logic [2:0] cw;
        logic       fr;
        logic [2:0] sel;
        logic       e_ar;
        logic       e_ci;
        logic       e_busy;
        logic       e_done;
        logic [3:0] e_fq;
        logic       e_fv;
        logic       e_ct;
    } vec_t;

    vec_t vecs[34];

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic ct_exp(input logic en_val);
`ifdef COND_EVAL_EN
        return en_val;
`else
        return 1'b0 & en_val;
`endif
    endfunction

    task automatic check_all(input int idx, input logic ar, input logic ci,
                             input logic b, input logic d, input logic [3:0] fq,
                             input logic fv, input logic ct);
        check("alu_ready", idx, {7'd0, bus.alu_ready}, {7'd0, ar});
        check("carry_in", idx, {7'd0, carry_in}, {7'd0, ci});
        check("chain_busy", idx, {7'd0, chain_busy}, {7'd0, b});
        check("chain_done", idx, {7'd0, chain_done}, {7'd0, d});
        check("flags_q", idx, {4'd0, bus.flags_q}, {4'd0, fq});
        check("flags_valid", idx, {7'd0, bus.flags_valid}, {7'd0, fv});
        check("cond_true", idx, {7'd0, cond_true}, {7'd0, ct_exp(ct)});
    endtask

    task automatic drive(input logic av, input logic [7:0] res, input logic c,
                         input logic v, input logic cs, input logic [2:0] cw,
                         input logic fr, input logic [2:0] sel);
        bus.alu_valid   = av;
        bus.result      = res;
        bus.c_flag      = c;
        bus.v_flag      = v;
        chain_start     = cs;
        chain_words     = cw;
        bus.flags_ready = fr;
        cond_sel        = sel;
    endtask

    initial begin
        //          av res   c v cs cw fr sel | ar ci b d fq       fv ct
        vecs[0]  = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0};
        vecs[1]  = '{1, 8'h00, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0};
        vecs[2]  = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0110, 1, 1};
        vecs[3]  = '{1, 8'h80, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0110, 1, 0};
        vecs[4]  = '{1, 8'h80, 0, 1, 0, 0, 1, 7, 1, 0, 0, 0, 4'b0110, 1, 1};
        vecs[5]  = '{0, 8'h00, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 4'b1001, 1, 1};
        vecs[6]  = '{0, 8'h00, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 4'b1001, 1, 1};
        vecs[7]  = '{0, 8'h00, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 4'b1001, 0, 0};
        vecs[8]  = '{1, 8'hFF, 1, 0, 1, 3, 0, 0, 1, 0, 0, 0, 4'b1001, 0, 0};
        vecs[9]  = '{1, 8'h00, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4'b1001, 0, 0};
        vecs[10] = '{1, 8'h01, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4'b1001, 0, 0};
        vecs[11] = '{0, 8'h00, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 4'b0000, 1, 1};
        vecs[12] = '{0, 8'h00, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 4'b0000, 1, 0};
        vecs[13] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0};
        vecs[14] = '{1, 8'h00, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0};
        vecs[15] = '{0, 8'h00, 0, 0, 1, 3, 0, 0, 1, 0, 1, 0, 4'b0000, 0, 0};
        vecs[16] = '{1, 8'h00, 0, 0, 1, 3, 0, 0, 1, 0, 1, 0, 4'b0000, 0, 0};
        vecs[17] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0100, 1, 1};
        vecs[18] = '{0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 4'b0100, 1, 0};
        vecs[19] = '{1, 8'h81, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 4'b0100, 0, 0};
        vecs[20] = '{0, 8'h00, 0, 0, 0, 0, 1, 7, 1, 0, 0, 1, 4'b1011, 1, 1};
        vecs[21] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1011, 0, 0};
        vecs[22] = '{0, 8'h00, 0, 0, 1, 7, 0, 0, 1, 0, 0, 0, 4'b1011, 0, 0};
        vecs[23] = '{1, 8'h10, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4'b1011, 0, 0};
        vecs[24] = '{1, 8'h20, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4'b1011, 0, 0};
        vecs[25] = '{1, 8'h30, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4'b1011, 0, 0};
        vecs[26] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4'b1011, 0, 0};
        vecs[27] = '{1, 8'hF0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4'b1011, 0, 0};
        vecs[28] = '{0, 8'h00, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1, 4'b1010, 1, 0};
        vecs[29] = '{1, 8'h00, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 4'b1010, 1, 0};
        vecs[30] = '{1, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1010, 1, 0};
        vecs[31] = '{1, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 4'b1010, 1, 0};
        vecs[32] = '{1, 8'h05, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 4'b1010, 0, 0};
        vecs[33] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 0};

        drive(0, 8'h00, 0, 0, 0, 3'd0, 0, 3'd0);
        #2;
        check_all(-1, 1, 0, 0, 0, 4'b0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].res, vecs[i].c, vecs[i].v,
                  vecs[i].cs, vecs[i].cw, vecs[i].fr, vecs[i].sel);
            #1;
            check_all(i, vecs[i].e_ar, vecs[i].e_ci, vecs[i].e_busy,
                      vecs[i].e_done, vecs[i].e_fq, vecs[i].e_fv, vecs[i].e_ct);
            @(posedge clk);
        end

        // Drain the last publish, then abort a 3-word chain mid-flight.
        @(negedge clk);
        drive(0, 8'h00, 0, 0, 0, 3'd0, 1, 3'd7);
        @(negedge clk);
        drive(1, 8'hFF, 1, 0, 1, 3'd3, 0, 3'd7);
        @(negedge clk);
        drive(1, 8'hFF, 1, 0, 0, 3'd0, 0, 3'd7);
        @(negedge clk);
        drive(0, 8'h00, 0, 0, 0, 3'd0, 0, 3'd7);
        #1;
        check_all(100, 1, 1, 1, 0, 4'b0001, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_all(101, 1, 0, 0, 0, 4'b0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 8'h7F, 0, 1, 0, 3'd0, 0, 3'd5);
        #1;
        check_all(102, 1, 0, 0, 0, 4'b0000, 0, 0);
        @(negedge clk);
        drive(0, 8'h00, 0, 0, 0, 3'd0, 0, 3'd5);
        #1;
        check_all(103, 0, 0, 0, 0, 4'b0001, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
